// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core : shared pipeline bus and stall/flush sequencer types
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package core;

  localparam int unsigned RCNT_W = 3;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } pipeline_bus_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    REDIRECT = 2'd2
  } pctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect : flags an EX load whose destination feeds an ID source
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module load_use_detect (
  input  logic [4:0] i_rd,
  input  logic [4:0] i_rs1,
  input  logic [4:0] i_rs2,
  input  logic       i_is_load,
  output logic       o_hazard
);

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign o_hazard = i_is_load && (i_rd != 5'd0) && ((i_rd == i_rs1) || (i_rd == i_rs2));

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl : stall/flush sequencer for the five-stage core
// Optional macro PIPE_CTRL_PERF_EN adds stall/flush cycle counters.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipeline_ctrl
  import core::*;
#(
  parameter int unsigned REDIRECT_CYCLES = 1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  pipeline_bus_t id_bus_i,
  input  pipeline_bus_t ex_bus_i,
  input  logic          ex_is_load_i,
  input  logic          ex_branch_taken_i,
  input  logic          ex_md_req_i,
  input  logic          md_done_i,
  input  logic          mem_req_i,
  input  logic          mem_ack_i,
  output logic          pc_stall_o,
  output logic          if_id_stall_o,
  output logic          id_ex_stall_o,
  output logic          ex_mem_stall_o,
  output logic          if_id_flush_o,
  output logic          id_ex_flush_o,
  output logic          ex_mem_flush_o,
  output logic          mem_wb_flush_o,
  output logic          md_start_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_cycles_o
`endif
);

  localparam logic [RCNT_W-1:0] C_RCNT_INIT = RCNT_W'(REDIRECT_CYCLES - 1);

  pctrl_state_t      r_state, w_state_nxt;
  logic [RCNT_W-1:0] r_rcnt, w_rcnt_nxt;
  logic              w_freeze, w_hazard, w_unused;
  logic w_pc_stall, w_if_id_stall, w_id_ex_stall, w_ex_mem_stall;
  logic w_if_id_flush, w_id_ex_flush, w_ex_mem_flush, w_mem_wb_flush, w_md_start;

  assign w_freeze = mem_req_i & ~mem_ack_i;
  assign w_unused = ^{id_bus_i.rd, ex_bus_i.rs1, ex_bus_i.rs2};

  load_use_detect u_load_use (
    .i_rd      (ex_bus_i.rd),
    .i_rs1     (id_bus_i.rs1),
    .i_rs2     (id_bus_i.rs2),
    .i_is_load (ex_is_load_i),
    .o_hazard  (w_hazard)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_rcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    if (!w_freeze) begin
      case (r_state)
        RUN: begin
          if (ex_branch_taken_i) begin
            if (REDIRECT_CYCLES > 1) begin
              w_state_nxt = REDIRECT;
              w_rcnt_nxt  = C_RCNT_INIT;
            end
          end else if (ex_md_req_i) begin
            w_state_nxt = MD_WAIT;
          end
        end
        MD_WAIT: if (md_done_i) w_state_nxt = RUN;
        REDIRECT: begin
          w_rcnt_nxt = r_rcnt - 1'b1;
          if (r_rcnt == RCNT_W'(1)) w_state_nxt = RUN;
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    {w_pc_stall, w_if_id_stall, w_id_ex_stall, w_ex_mem_stall} = '0;
    {w_if_id_flush, w_id_ex_flush, w_ex_mem_flush, w_mem_wb_flush, w_md_start} = '0;
    if (w_freeze) begin
      {w_pc_stall, w_if_id_stall, w_id_ex_stall, w_ex_mem_stall} = '1;
      w_mem_wb_flush = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (ex_branch_taken_i) begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
          end else if (ex_md_req_i) begin
            w_md_start = 1'b1;
            {w_pc_stall, w_if_id_stall, w_id_ex_stall} = '1;
            w_ex_mem_flush = 1'b1;
          end else if (w_hazard) begin
            {w_pc_stall, w_if_id_stall} = '1;
            w_id_ex_flush = 1'b1;
          end
        end
        MD_WAIT: begin
          // done releases everything at once so the result advances this cycle
          if (!md_done_i) begin
            {w_pc_stall, w_if_id_stall, w_id_ex_stall} = '1;
            w_ex_mem_flush = 1'b1;
          end
        end
        REDIRECT: begin
          w_if_id_flush = 1'b1;
          if (w_hazard) begin
            {w_pc_stall, w_if_id_stall} = '1;
            w_id_ex_flush = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced low for the whole time reset is held
  assign {pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o,
          if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o, md_start_o} =
         rst ? {w_pc_stall, w_if_id_stall, w_id_ex_stall, w_ex_mem_stall,
                w_if_id_flush, w_id_ex_flush, w_ex_mem_flush, w_mem_wb_flush, w_md_start}
             : 9'd0;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (pc_stall_o)    r_stall_cnt <= r_stall_cnt + 1'b1;
      if (if_id_flush_o) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cycles_o = r_stall_cnt;
  assign flush_cycles_o = r_flush_cnt;
`else
  localparam int unsigned C_UNUSED_CNT_W = CNT_W;
`endif

endmodule

`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the five-stage core. It resolves load-use hazards that forwarding cannot cover, and holds the front end while a multi-cycle mul/div executes in EX. It also freezes the whole pipeline during data-memory wait states and bubbles fetch for a configurable redirect window after a taken branch. It sits beside the forwarding controller, reads the ID and EX pipeline buses, and drives the stall/flush enables of every pipeline register.

## Interface
- REDIRECT_CYCLES, 1, total cycles if_id_flush_o is asserted per taken branch; legal 1..7
- CNT_W, 32, width of performance counters (only used with PIPE_CTRL_PERF_EN)

- clk  in  1  core clock
- rst  in  1  reset; one clock, reset asynchronous and active-low
- id_bus_i  in  core::pipeline_bus_t  ID-stage bus; rs1, rs2 used
- ex_bus_i  in  core::pipeline_bus_t  EX-stage bus; rd used
- ex_is_load_i  in  1  EX holds a load
- ex_branch_taken_i  in  1  EX resolved a taken branch/jump
- ex_md_req_i  in  1  EX holds a mul/div op; mutually exclusive with ex_branch_taken_i
- md_done_i  in  1  mul/div result valid; held high until consumed
- mem_req_i  in  1  MEM stage has a data-memory access outstanding
- mem_ack_i  in  1  data memory completes access this cycle
- pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o  out  1 each  hold register
- if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o  out  1 each  insert bubble
- md_start_o  out  1  one-cycle start pulse to the mul/div unit

## Operation
- States (core::pctrl_state_t): RUN, MD_WAIT, REDIRECT. Redirect counter rcnt is 3 bits.
- Outputs are combinational from state, rcnt and inputs. State and rcnt are registered.
- Freeze = mem_req_i & ~mem_ack_i. While frozen, the following apply in every state:
  - pc, if_id, id_ex and ex_mem stall; mem_wb_flush_o=1.
  - All other flush outputs and md_start_o are 0.
  - State and rcnt hold. md_done_i and ex_branch_taken_i are not consumed.
- RUN, not frozen, priority order:
  1. ex_branch_taken_i: if_id_flush_o=id_ex_flush_o=1. If REDIRECT_CYCLES>1, go to REDIRECT with rcnt=REDIRECT_CYCLES-1.
  2. ex_md_req_i: md_start_o=1; pc, if_id, id_ex stall; ex_mem_flush_o=1; go to MD_WAIT. md_done_i is ignored in this cycle.
  3. Load-use (ex_is_load_i, ex rd≠0, rd==id rs1 or rd==id rs2): pc and if_id stall; id_ex_flush_o=1; stay in RUN.
- MD_WAIT, not frozen:
  - md_done_i=0: pc, if_id, id_ex stall; ex_mem_flush_o=1.
  - md_done_i=1: all outputs 0, so the result advances; go to RUN.
- REDIRECT, not frozen:
  - if_id_flush_o=1; rcnt decrements.
  - rcnt==1 leads to RUN. Load-use detection still applies (priority 3).
- While rst is low: state=RUN, rcnt=0, and every output is 0.

## Timing
- Load-use costs exactly 1 bubble cycle. The load has moved to MEM on the next cycle, so the hazard clears.
- Taken-branch penalty is 1+(REDIRECT_CYCLES-1) fetch bubbles; the ID/EX bubble is 1 cycle.
- Mul/div penalty: md_start_o in cycle N; stall from N through the cycle md_done_i is seen; release in that same cycle.
- Freeze takes effect in the same cycle and extends every other sequence cycle-for-cycle.
- Reset asserted mid-sequence aborts it immediately. After deassertion the block starts in RUN.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - Adds outputs stall_cycles_o and flush_cycles_o, each CNT_W wide.
  - stall_cycles_o counts cycles with pc_stall_o=1.
  - flush_cycles_o counts cycles with if_id_flush_o=1.
  - Both reset to 0 and wrap modulo 2^CNT_W.
- PIPE_CTRL_PERF_EN undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- core package holds pctrl_state_t (RUN/MD_WAIT/REDIRECT) and a localparam for the rcnt width (3).
- One combinational sub-module, load_use_detect (rd, rs1, rs2, is_load -> hazard), reused by verification checkers.

## Test plan
- EX load with rd=5, ID rs2=5 in RUN -> one cycle of pc_stall_o=if_id_stall_o=id_ex_flush_o=1, then all 0. Same case with rd=0 -> no stall.
- REDIRECT_CYCLES=3, ex_branch_taken_i pulse -> if_id_flush_o high for 3 cycles, id_ex_flush_o high for the first cycle only, then RUN.
- ex_md_req_i high with md_done_i arriving 4 cycles later -> md_start_o pulses once; stalls and ex_mem_flush_o last 4 cycles; released on the done cycle.
- mem_req_i=1 with ack 3 cycles later during MD_WAIT with done held high -> all four stalls plus mem_wb_flush_o for 3 cycles; done consumed on the ack cycle.
- Branch taken during freeze -> no flush until mem_ack_i; flush occurs in the ack cycle.
- rst low in REDIRECT with rcnt=2 -> outputs 0 immediately; after release, the next branch gives a full 3-cycle redirect. With PIPE_CTRL_PERF_EN, counters read 0.
